// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller for the E-stage multiply/divide unit: qualifies starts
// and HI/LO moves against flushes, times the MDU run and drives the D-stage stall.
module mdu_issue_ctrl #(
  parameter int OP_W        = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter logic [OP_W-1:0] MDU_MULT  = OP_W'(1),
  parameter logic [OP_W-1:0] MDU_MULTU = OP_W'(2),
  parameter logic [OP_W-1:0] MDU_DIV   = OP_W'(3),
  parameter logic [OP_W-1:0] MDU_DIVU  = OP_W'(4),
  parameter logic [OP_W-1:0] MDU_MFHI  = OP_W'(5),
  parameter logic [OP_W-1:0] MDU_MFLO  = OP_W'(6),
  parameter logic [OP_W-1:0] MDU_MTHI  = OP_W'(7),
  parameter logic [OP_W-1:0] MDU_MTLO  = OP_W'(8)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_Req,
  input  logic            i_D_isMdu,
  input  logic [OP_W-1:0] i_E_mduOp,
  input  logic            i_E_start,
  output logic            o_start,
  output logic            o_hiWe,
  output logic            o_loWe,
  output logic            o_busy,
  output logic            o_stall,
  output logic            o_commit,
  output logic [1:0]      o_state,
  output logic            o_err
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_isMul;
  logic w_isDiv;
  logic w_idle;
  logic w_running;
  logic w_start;
  logic w_misuse;

  assign w_isMul   = (i_E_mduOp == MDU_MULT) | (i_E_mduOp == MDU_MULTU);
  assign w_isDiv   = (i_E_mduOp == MDU_DIV)  | (i_E_mduOp == MDU_DIVU);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_running = (r_state == ST_MUL) | (r_state == ST_DIV);
  assign w_start   = i_E_start & ~i_Req & w_idle & (w_isMul | w_isDiv);
  // A start request that arrives while the unit is not idle is dropped and flagged.
  assign w_misuse  = i_E_start & (w_isMul | w_isDiv) & ~w_idle;

  assign o_start  = w_start;
  assign o_hiWe   = (i_E_mduOp == MDU_MTHI) & ~i_Req & w_idle;
  assign o_loWe   = (i_E_mduOp == MDU_MTLO) & ~i_Req & w_idle;
  assign o_busy   = w_start | ~w_idle;
  assign o_stall  = i_D_isMdu & o_busy;
  assign o_commit = w_running & (r_cnt == CNT_ONE);
  assign o_state  = r_state;
  assign o_err    = r_err;

  // Run-latency FSM, countdown counter and sticky misuse flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_err   <= 1'b0;
    end else begin
      if (w_misuse) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start && w_isMul) begin
            r_state <= ST_MUL;
            r_cnt   <= MULT_CNT;
          end else if (w_start) begin
            r_state <= ST_DIV;
            r_cnt   <= DIV_CNT;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        ST_MUL, ST_DIV: begin
          // cnt==0 cannot occur while running; treating it as done avoids a lockup.
          if (r_cnt <= CNT_ONE) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_state <= r_state;
            r_cnt   <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule
